instruction_encoder: RTL

- Converts structured operation descriptors into 32-bit RV32IM instruction words. Covers exactly the subset the core's decoder accepts.
- Stamps each word with a sequential instruction-memory word address and buffers it for a downstream memory writer.
- Sits between the debug/boot-loader command front end and instruction memory.
- Valid/ready on both sides; illegal descriptors are dropped and flagged.

---
 rtl/instruction_encoder_pkg.sv | 65 ++++++
 rtl/instruction_encoder_fifo.sv | 50 +++++
 rtl/instruction_encoder.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/instruction_encoder_pkg.sv
// Shared RV32IM encoding constants, op enumeration, error codes and immediate limits
// used by the instruction encoder (values match the core's decoder).
package instruction_encoder_pkg;

  localparam int unsigned INSTRUCTION_WIDTH = 32;
  localparam int unsigned DATA_WIDTH        = 32;
  localparam int unsigned REGADDR_WIDTH     = 5;
  localparam int unsigned OP_WIDTH          = 5;

  typedef enum logic [OP_WIDTH-1:0] {
    OP_ADDI = 5'd0,  OP_SLTI = 5'd1,  OP_SLTIU = 5'd2,
    OP_ADD  = 5'd3,  OP_SUB  = 5'd4,  OP_SLT   = 5'd5,  OP_SLTU = 5'd6,
    OP_MUL  = 5'd7,  OP_DIV  = 5'd8,  OP_DIVU  = 5'd9,  OP_REM  = 5'd10, OP_REMU = 5'd11,
    OP_JAL  = 5'd12,
    OP_BEQ  = 5'd13, OP_BNE  = 5'd14, OP_BLT   = 5'd15, OP_BGE  = 5'd16,
    OP_BLTU = 5'd17, OP_BGEU = 5'd18,
    OP_LB   = 5'd19, OP_LH   = 5'd20, OP_LW    = 5'd21, OP_LBU  = 5'd22, OP_LHU  = 5'd23,
    OP_SB   = 5'd24, OP_SH   = 5'd25, OP_SW    = 5'd26
  } op_e;

  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_JAL    = 7'h6f;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_STORE  = 7'h23;

  localparam logic [2:0] F3_ADD  = 3'd0, F3_SLT  = 3'd2, F3_SLTU = 3'd3;
  localparam logic [2:0] F3_MUL  = 3'd0, F3_DIV  = 3'd4, F3_DIVU = 3'd5;
  localparam logic [2:0] F3_REM  = 3'd6, F3_REMU = 3'd7;
  localparam logic [2:0] F3_BEQ  = 3'd0, F3_BNE  = 3'd1, F3_BLT  = 3'd4;
  localparam logic [2:0] F3_BGE  = 3'd5, F3_BLTU = 3'd6, F3_BGEU = 3'd7;
  localparam logic [2:0] F3_LB   = 3'd0, F3_LH   = 3'd1, F3_LW   = 3'd2;
  localparam logic [2:0] F3_LBU  = 3'd4, F3_LHU  = 3'd5;
  localparam logic [2:0] F3_SB   = 3'd0, F3_SH   = 3'd1, F3_SW   = 3'd2;

  localparam logic [6:0] F7_BASE   = 7'h00;
  localparam logic [6:0] F7_SUB    = 7'h20;
  localparam logic [6:0] F7_MULDIV = 7'h01;

  typedef enum logic [1:0] {
    ERR_NONE       = 2'd0,
    ERR_ILLEGAL_OP = 2'd1,
    ERR_IMM_RANGE  = 2'd2,
    ERR_ODD_OFFSET = 2'd3
  } err_code_e;

  typedef enum logic [2:0] {FMT_I, FMT_R, FMT_S, FMT_B, FMT_J, FMT_BAD} fmt_e;

  localparam int IMM12_MIN = -2048;
  localparam int IMM12_MAX = 2047;
  localparam int IMM_B_MIN = -4096;
  localparam int IMM_B_MAX = 4094;
  localparam int IMM_J_MIN = -1048576;
  localparam int IMM_J_MAX = 1048574;

  typedef struct packed {
    logic [OP_WIDTH-1:0]      op;
    logic [REGADDR_WIDTH-1:0] rd;
    logic [REGADDR_WIDTH-1:0] rs1;
    logic [REGADDR_WIDTH-1:0] rs2;
    logic [DATA_WIDTH-1:0]    imm;
  } desc_t;

endpackage

// File: rtl/instruction_encoder_fifo.sv
// Two-entry synchronous FIFO with flush; simultaneous push and pop allowed when full.
module instruction_encoder_fifo #(
  parameter int unsigned WIDTH = 42
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       used;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      used   <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      used   <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   used <= used + 2'd1;
        2'b01:   used <= used - 2'd1;
        default: used <= used;
      endcase
    end
  end

  assign rdata = mem[rd_ptr];
  assign full  = (used == 2'd2);
  assign empty = (used == 2'd0);

endmodule

// File: rtl/instruction_encoder.sv
// Encodes operation descriptors into RV32IM words, stamps each with a sequential
// instruction-memory address and buffers it for the memory writer.
module instruction_encoder
  import instruction_encoder_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned BASE_ADDR  = 0
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [OP_WIDTH-1:0]          op,
  input  logic [REGADDR_WIDTH-1:0]     rd,
  input  logic [REGADDR_WIDTH-1:0]     rs1,
  input  logic [REGADDR_WIDTH-1:0]     rs2,
  input  logic [DATA_WIDTH-1:0]        imm,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [INSTRUCTION_WIDTH-1:0] out_instruction,
  output logic [ADDR_WIDTH-1:0]        out_addr,
  output logic [ADDR_WIDTH:0]          count,
  output logic                         err,
  output logic [1:0]                   err_code
);

  localparam int unsigned            FIFO_W    = INSTRUCTION_WIDTH + ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0]  ADDR_RST  = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH:0]    COUNT_MAX = {1'b1, {ADDR_WIDTH{1'b0}}};

  desc_t                         s1;
  logic                          s1_valid;
  fmt_e                          fmt;
  logic [6:0]                    opcode;
  logic [2:0]                    funct3;
  logic [6:0]                    funct7;
  logic [INSTRUCTION_WIDTH-1:0]  word_c;
  err_code_e                     chk_c;
  logic signed [DATA_WIDTH-1:0]  simm;
  logic                          illegal;
  logic                          fifo_full;
  logic                          fifo_empty;
  logic                          pop;
  logic                          fifo_space;
  logic                          s1_move;
  logic                          push;
  logic                          accept;
  logic [ADDR_WIDTH-1:0]         next_addr;
  logic [FIFO_W-1:0]             fifo_rdata;
  logic [INSTRUCTION_WIDTH-1:0]  fifo_instr;
  logic [ADDR_WIDTH-1:0]         fifo_addr;

  assign simm = $signed(s1.imm);

  // Format, opcode and funct fields for the descriptor held in stage 1
  always_comb begin
    fmt    = FMT_BAD;
    opcode = '0;
    funct3 = '0;
    funct7 = F7_BASE;
    case (s1.op)
      OP_ADDI:  begin fmt = FMT_I; opcode = OPC_OP_IMM; funct3 = F3_ADD;  end
      OP_SLTI:  begin fmt = FMT_I; opcode = OPC_OP_IMM; funct3 = F3_SLT;  end
      OP_SLTIU: begin fmt = FMT_I; opcode = OPC_OP_IMM; funct3 = F3_SLTU; end
      OP_ADD:   begin fmt = FMT_R; opcode = OPC_OP; funct3 = F3_ADD;  end
      OP_SUB:   begin fmt = FMT_R; opcode = OPC_OP; funct3 = F3_ADD;  funct7 = F7_SUB;    end
      OP_SLT:   begin fmt = FMT_R; opcode = OPC_OP; funct3 = F3_SLT;  end
      OP_SLTU:  begin fmt = FMT_R; opcode = OPC_OP; funct3 = F3_SLTU; end
      OP_MUL:   begin fmt = FMT_R; opcode = OPC_OP; funct3 = F3_MUL;  funct7 = F7_MULDIV; end
      OP_DIV:   begin fmt = FMT_R; opcode = OPC_OP; funct3 = F3_DIV;  funct7 = F7_MULDIV; end
      OP_DIVU:  begin fmt = FMT_R; opcode = OPC_OP; funct3 = F3_DIVU; funct7 = F7_MULDIV; end
      OP_REM:   begin fmt = FMT_R; opcode = OPC_OP; funct3 = F3_REM;  funct7 = F7_MULDIV; end
      OP_REMU:  begin fmt = FMT_R; opcode = OPC_OP; funct3 = F3_REMU; funct7 = F7_MULDIV; end
      OP_JAL:   begin fmt = FMT_J; opcode = OPC_JAL; end
      OP_BEQ:   begin fmt = FMT_B; opcode = OPC_BRANCH; funct3 = F3_BEQ;  end
      OP_BNE:   begin fmt = FMT_B; opcode = OPC_BRANCH; funct3 = F3_BNE;  end
      OP_BLT:   begin fmt = FMT_B; opcode = OPC_BRANCH; funct3 = F3_BLT;  end
      OP_BGE:   begin fmt = FMT_B; opcode = OPC_BRANCH; funct3 = F3_BGE;  end
      OP_BLTU:  begin fmt = FMT_B; opcode = OPC_BRANCH; funct3 = F3_BLTU; end
      OP_BGEU:  begin fmt = FMT_B; opcode = OPC_BRANCH; funct3 = F3_BGEU; end
      OP_LB:    begin fmt = FMT_I; opcode = OPC_LOAD;  funct3 = F3_LB;  end
      OP_LH:    begin fmt = FMT_I; opcode = OPC_LOAD;  funct3 = F3_LH;  end
      OP_LW:    begin fmt = FMT_I; opcode = OPC_LOAD;  funct3 = F3_LW;  end
      OP_LBU:   begin fmt = FMT_I; opcode = OPC_LOAD;  funct3 = F3_LBU; end
      OP_LHU:   begin fmt = FMT_I; opcode = OPC_LOAD;  funct3 = F3_LHU; end
      OP_SB:    begin fmt = FMT_S; opcode = OPC_STORE; funct3 = F3_SB;  end
      OP_SH:    begin fmt = FMT_S; opcode = OPC_STORE; funct3 = F3_SH;  end
      OP_SW:    begin fmt = FMT_S; opcode = OPC_STORE; funct3 = F3_SW;  end
      default:  fmt = FMT_BAD;
    endcase
  end

  // Field packing; unused register fields of each format stay zero
  always_comb begin
    word_c = '0;
    case (fmt)
      FMT_I: word_c = {s1.imm[11:0], s1.rs1, funct3, s1.rd, opcode};
      FMT_R: word_c = {funct7, s1.rs2, s1.rs1, funct3, s1.rd, opcode};
      FMT_S: word_c = {s1.imm[11:5], s1.rs2, s1.rs1, funct3, s1.imm[4:0], opcode};
      FMT_B: word_c = {s1.imm[12], s1.imm[10:5], s1.rs2, s1.rs1, funct3,
                       s1.imm[4:1], s1.imm[11], opcode};
      FMT_J: word_c = {s1.imm[20], s1.imm[10:1], s1.imm[11], s1.imm[19:12], s1.rd, opcode};
      default: word_c = '0;
    endcase
  end

  // Legality check; earlier tests win so the code reflects the highest-priority fault
  always_comb begin
    chk_c = ERR_NONE;
    case (fmt)
      FMT_I, FMT_S: if (simm < IMM12_MIN || simm > IMM12_MAX) chk_c = ERR_IMM_RANGE;
      FMT_B: begin
        if (simm < IMM_B_MIN || simm > IMM_B_MAX) chk_c = ERR_IMM_RANGE;
        else if (s1.imm[0])                       chk_c = ERR_ODD_OFFSET;
      end
      FMT_J: begin
        if (simm < IMM_J_MIN || simm > IMM_J_MAX) chk_c = ERR_IMM_RANGE;
        else if (s1.imm[0])                       chk_c = ERR_ODD_OFFSET;
      end
      FMT_R:   chk_c = ERR_NONE;
      default: chk_c = ERR_ILLEGAL_OP;
    endcase
  end

  assign illegal    = (chk_c != ERR_NONE);
  assign pop        = out_valid && out_ready;
  assign fifo_space = !fifo_full || pop;
  assign s1_move    = s1_valid && (illegal || fifo_space);
  assign push       = !flush && s1_valid && !illegal && fifo_space;
  assign in_ready   = !flush && (!s1_valid || s1_move);
  assign accept     = in_valid && in_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1       <= '0;
    end else if (flush) begin
      s1_valid <= 1'b0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1       <= {op, rd, rs1, rs2, imm};
    end else if (s1_move) begin
      s1_valid <= 1'b0;
    end
  end

  // Address/count advance only on real FIFO writes; the first error code is kept
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      next_addr <= ADDR_RST;
      count     <= '0;
      err       <= 1'b0;
      err_code  <= ERR_NONE;
    end else if (flush) begin
      next_addr <= ADDR_RST;
      count     <= '0;
      err       <= 1'b0;
      err_code  <= ERR_NONE;
    end else begin
      if (push) begin
        next_addr <= next_addr + ADDR_WIDTH'(1);
        if (count != COUNT_MAX) count <= count + (ADDR_WIDTH+1)'(1);
      end
      if (s1_valid && illegal) begin
        err <= 1'b1;
        if (!err) err_code <= chk_c;
      end
    end
  end

  instruction_encoder_fifo #(
    .WIDTH (FIFO_W)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (flush),
    .push    (push),
    .wdata   ({word_c, next_addr}),
    .pop     (pop),
    .rdata   (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign {fifo_instr, fifo_addr} = fifo_rdata;
  assign out_valid       = !fifo_empty;
  assign out_instruction = out_valid ? fifo_instr : '0;
  assign out_addr        = out_valid ? fifo_addr : next_addr;

endmodule
